// File: rtl/term_postfix_writer.sv
// ---------------------------------------------------------------------------
// term_postfix_writer
//
// Converts an infix term token stream into postfix order using a
// shunting-yard operator stack. Each postfix token goes into the term-detail
// postfix memory as one 9-bit word, and the term ends with the end-of-term
// word 10111_0000. term_accumulator later reads and evaluates these words.
//
// Optional feature macro: TERM_POSTFIX_WRITER_PAREN_EN
//   defined   : open/close paren opcodes are handled (POP_PAREN state exists)
//   undefined : paren opcodes are illegal and raise error code 11
//
// Ports
//   clock, reset                     single clock, async active-high reset
//   term_writer_start                one-cycle start pulse, sampled in IDLE
//   term_base_addr                   first write address, latched on start
//   token_valid / token_ready        infix token handshake
//   token_data                       infix token
//   mem_term_detail_postfix_addr     write address
//   mem_term_detail_postfix_data_in  write data
//   mem_term_detail_postfix_wr_en    write strobe, one word per cycle
//   term_writer_busy                 high outside IDLE
//   term_writer_done                 one-cycle pulse on successful completion
//   term_writer_error / _error_code  sticky until the next start
//   term_length                      words written incl. end word, valid with done
// ---------------------------------------------------------------------------
module term_postfix_writer #(
    parameter int POSTFIX_DATA_WIDTH = 9,
    parameter int ADDR_WIDTH         = 8,
    parameter int OP_STACK_DEPTH     = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          term_writer_start,
    input  logic [ADDR_WIDTH-1:0]         term_base_addr,
    input  logic                          token_valid,
    output logic                          token_ready,
    input  logic [POSTFIX_DATA_WIDTH-1:0] token_data,
    output logic [ADDR_WIDTH-1:0]         mem_term_detail_postfix_addr,
    output logic [POSTFIX_DATA_WIDTH-1:0] mem_term_detail_postfix_data_in,
    output logic                          mem_term_detail_postfix_wr_en,
    output logic                          term_writer_busy,
    output logic                          term_writer_done,
    output logic                          term_writer_error,
    output logic [1:0]                    term_writer_error_code,
    output logic [ADDR_WIDTH-1:0]         term_length
);

    localparam int SP_W = $clog2(OP_STACK_DEPTH);

    // Low three opcode bits; the upper two are always 10 for operator tokens.
    localparam logic [2:0] OPC_MUL   = 3'd0;
    localparam logic [2:0] OPC_ADD   = 3'd1;
    localparam logic [2:0] OPC_SUB   = 3'd2;
    localparam logic [2:0] OPC_DIV   = 3'd3;
    localparam logic [2:0] OPC_EXP   = 3'd4;
    localparam logic [2:0] OPC_OPEN  = 3'd5;
    localparam logic [2:0] OPC_CLOSE = 3'd6;
    localparam logic [2:0] OPC_END   = 3'd7;

    localparam logic [1:0] ERR_STACK = 2'b01;
    localparam logic [1:0] ERR_PAREN = 2'b10;
    localparam logic [1:0] ERR_ILLEG = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCEPT,
        S_POP_OP,
`ifdef TERM_POSTFIX_WRITER_PAREN_EN
        S_POP_PAREN,
`endif
        S_FLUSH,
        S_WRITE_END,
        S_DONE,
        S_ERROR
    } state_t;

    state_t r_state;
    state_t w_nextState;

    logic [ADDR_WIDTH-1:0]         r_base;
    logic [ADDR_WIDTH:0]           r_ptr;
    logic [SP_W:0]                 r_sp;
    logic [2:0]                    r_stack [OP_STACK_DEPTH];
    logic [2:0]                    r_inOp;
    logic                          r_wrEn;
    logic [ADDR_WIDTH-1:0]         r_addr;
    logic [POSTFIX_DATA_WIDTH-1:0] r_data;
    logic                          r_done;
    logic                          r_err;
    logic [1:0]                    r_errCode;
    logic [ADDR_WIDTH-1:0]         r_termLen;

    logic                          w_start;
    logic                          w_tokIsOp;
    logic [2:0]                    w_tokOpc;
    logic                          w_tokIllegal;
    logic                          w_empty;
    logic                          w_full;
    logic [SP_W-1:0]               w_topIdx;
    logic [2:0]                    w_topOp;
    logic                          w_topIsOpen;
    logic                          w_popRule;
    logic [ADDR_WIDTH:0]           w_wrIdx;
    logic [ADDR_WIDTH:0]           w_wrAddrFull;
    logic                          w_memOvf;

    logic                          w_doWrite;
    logic [POSTFIX_DATA_WIDTH-1:0] w_wrData;
    logic                          w_push;
    logic                          w_pop;
    logic                          w_latchOp;
    logic                          w_errSet;
    logic [1:0]                    w_errCode;

    function automatic logic [1:0] precOf(input logic [2:0] op);
        case (op)
            OPC_EXP:          return 2'd3;
            OPC_MUL, OPC_DIV: return 2'd2;
            OPC_ADD, OPC_SUB: return 2'd1;
            default:          return 2'd0;
        endcase
    endfunction

    assign w_start   = (r_state == S_IDLE) && term_writer_start;
    assign w_tokIsOp = (token_data[8:7] == 2'b10);
    assign w_tokOpc  = token_data[6:4];

`ifdef TERM_POSTFIX_WRITER_PAREN_EN
    assign w_tokIllegal = 1'b0;
`else
    assign w_tokIllegal = (w_tokOpc == OPC_OPEN) || (w_tokOpc == OPC_CLOSE);
`endif

    assign w_empty     = (r_sp == '0);
    assign w_full      = (r_sp == (SP_W+1)'(OP_STACK_DEPTH));
    assign w_topIdx    = r_sp[SP_W-1:0] - SP_W'(1);
    assign w_topOp     = r_stack[w_topIdx];
    assign w_topIsOpen = !w_empty && (w_topOp == OPC_OPEN);

    // Pop while the top binds tighter, or equally tight with a left-associative
    // incoming operator. An incoming open paren never pops, and an open paren
    // on the stack (precedence 0) is never popped by an operator.
    assign w_popRule = !w_empty && (r_inOp != OPC_OPEN) &&
                       ((precOf(w_topOp) > precOf(r_inOp)) ||
                        ((precOf(w_topOp) == precOf(r_inOp)) && (r_inOp != OPC_EXP)));

    // The pointer counts words whose strobe has already been on the bus; a
    // strobe still showing this cycle has not been counted yet.
    assign w_wrIdx      = r_ptr + {{ADDR_WIDTH{1'b0}}, r_wrEn};
    assign w_wrAddrFull = {1'b0, r_base} + w_wrIdx;
    assign w_memOvf     = w_wrAddrFull[ADDR_WIDTH];

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic; any detected error diverts to ERROR for one cycle.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (term_writer_start) w_nextState = S_ACCEPT;
            end
            S_ACCEPT: begin
                if (token_valid) begin
                    if (w_errSet) begin
                        w_nextState = S_ERROR;
                    end else if (w_tokIsOp) begin
                        case (w_tokOpc)
`ifdef TERM_POSTFIX_WRITER_PAREN_EN
                            OPC_CLOSE: w_nextState = S_POP_PAREN;
`endif
                            OPC_END:   w_nextState = S_FLUSH;
                            default:   w_nextState = S_POP_OP;
                        endcase
                    end
                end
            end
            S_POP_OP: begin
                if (w_errSet)       w_nextState = S_ERROR;
                else if (!w_popRule) w_nextState = S_ACCEPT;
            end
`ifdef TERM_POSTFIX_WRITER_PAREN_EN
            S_POP_PAREN: begin
                if (w_errSet)         w_nextState = S_ERROR;
                else if (w_topIsOpen) w_nextState = S_ACCEPT;
            end
`endif
            S_FLUSH: begin
                // Leave on the last pop so the end word follows it directly.
                if (w_errSet)
                    w_nextState = S_ERROR;
                else if (w_empty || (r_sp == (SP_W+1)'(1)))
                    w_nextState = S_WRITE_END;
            end
            S_WRITE_END: begin
                w_nextState = w_errSet ? S_ERROR : S_DONE;
            end
            S_DONE:  w_nextState = S_IDLE;
            S_ERROR: w_nextState = S_IDLE;
            default: w_nextState = S_IDLE;
        endcase
    end

    // Per-state datapath controls: at most one write and one stack action.
    always_comb begin
        w_doWrite = 1'b0;
        w_wrData  = '0;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_latchOp = 1'b0;
        w_errSet  = 1'b0;
        w_errCode = 2'b00;
        case (r_state)
            S_ACCEPT: begin
                if (token_valid) begin
                    if (!w_tokIsOp) begin
                        if (w_memOvf) begin
                            w_errSet  = 1'b1;
                            w_errCode = ERR_ILLEG;
                        end else begin
                            w_doWrite = 1'b1;
                            w_wrData  = token_data;
                        end
                    end else if (w_tokIllegal) begin
                        w_errSet  = 1'b1;
                        w_errCode = ERR_ILLEG;
                    end else begin
                        w_latchOp = 1'b1;
                    end
                end
            end
            S_POP_OP: begin
                if (w_popRule) begin
                    if (w_memOvf) begin
                        w_errSet  = 1'b1;
                        w_errCode = ERR_ILLEG;
                    end else begin
                        w_doWrite = 1'b1;
                        w_wrData  = {2'b10, w_topOp, 4'b0000};
                        w_pop     = 1'b1;
                    end
                end else if (w_full) begin
                    w_errSet  = 1'b1;
                    w_errCode = ERR_STACK;
                end else begin
                    w_push = 1'b1;
                end
            end
`ifdef TERM_POSTFIX_WRITER_PAREN_EN
            S_POP_PAREN: begin
                if (w_empty) begin
                    w_errSet  = 1'b1;
                    w_errCode = ERR_PAREN;
                end else if (w_topIsOpen) begin
                    w_pop = 1'b1;
                end else if (w_memOvf) begin
                    w_errSet  = 1'b1;
                    w_errCode = ERR_ILLEG;
                end else begin
                    w_doWrite = 1'b1;
                    w_wrData  = {2'b10, w_topOp, 4'b0000};
                    w_pop     = 1'b1;
                end
            end
`endif
            S_FLUSH: begin
                if (w_empty) begin
                    w_doWrite = 1'b0;
                end else if (w_topIsOpen) begin
                    w_errSet  = 1'b1;
                    w_errCode = ERR_PAREN;
                end else if (w_memOvf) begin
                    w_errSet  = 1'b1;
                    w_errCode = ERR_ILLEG;
                end else begin
                    w_doWrite = 1'b1;
                    w_wrData  = {2'b10, w_topOp, 4'b0000};
                    w_pop     = 1'b1;
                end
            end
            S_WRITE_END: begin
                if (w_memOvf) begin
                    w_errSet  = 1'b1;
                    w_errCode = ERR_ILLEG;
                end else begin
                    w_doWrite = 1'b1;
                    w_wrData  = {2'b10, OPC_END, 4'b0000};
                end
            end
            default: begin
                w_doWrite = 1'b0;
            end
        endcase
    end

    // Registered outputs, pointer, stack pointer and sticky error.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_base    <= '0;
            r_ptr     <= '0;
            r_sp      <= '0;
            r_inOp    <= '0;
            r_wrEn    <= 1'b0;
            r_addr    <= '0;
            r_data    <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_errCode <= 2'b00;
            r_termLen <= '0;
        end else begin
            r_wrEn <= w_doWrite;
            r_done <= (r_state == S_DONE);
            if (w_doWrite) begin
                r_addr <= w_wrAddrFull[ADDR_WIDTH-1:0];
                r_data <= w_wrData;
            end
            if (w_latchOp) begin
                r_inOp <= w_tokOpc;
            end
            if (r_state == S_DONE) begin
                r_termLen <= w_wrIdx[ADDR_WIDTH-1:0];
            end
            if (w_start) begin
                r_base    <= term_base_addr;
                r_ptr     <= '0;
                r_sp      <= '0;
                r_err     <= 1'b0;
                r_errCode <= 2'b00;
            end else begin
                if (r_wrEn) begin
                    r_ptr <= r_ptr + (ADDR_WIDTH+1)'(1);
                end
                if (w_push) begin
                    r_sp <= r_sp + (SP_W+1)'(1);
                end else if (w_pop) begin
                    r_sp <= r_sp - (SP_W+1)'(1);
                end
                if (w_errSet) begin
                    r_err     <= 1'b1;
                    r_errCode <= w_errCode;
                end
            end
        end
    end

    // Stack storage needs no reset; only entries below r_sp are ever read.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_stack[r_sp[SP_W-1:0]] <= r_inOp;
        end
    end

    assign token_ready                     = (r_state == S_ACCEPT);
    assign term_writer_busy                = (r_state != S_IDLE);
    assign mem_term_detail_postfix_addr    = r_addr;
    assign mem_term_detail_postfix_data_in = r_data;
    assign mem_term_detail_postfix_wr_en   = r_wrEn;
    assign term_writer_done                = r_done;
    assign term_writer_error               = r_err;
    assign term_writer_error_code          = r_errCode;
    assign term_length                     = r_termLen;

endmodule
